// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator with a shared period counter.
// Each channel compares the shared count against its own duty. Period, duty
// and alignment mode are double-buffered; a captured set becomes active only
// at a period boundary, or on any clock while idle.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         run enable
//   load       1-clk strobe: capture cycle/duty/center into the pending set
//   cycle      period length C (clocks per edge-aligned period)
//   duty       per-channel duty, channel i = duty[i*WIDTH +: WIDTH]
//   center     0 = edge-aligned, 1 = center-aligned
//   pwm_out    registered PWM outputs
//   period_end 1-clk pulse aligned with the last clock of each period
//   load_ack   1-clk pulse when the pending set becomes active
//
// Counter direction states
//   state    | meaning
//   DIR_UP   | counting 1..C (edge mode always stays here)
//   DIR_DOWN | center mode, counting C..1
module pwm_multi_ch #(
  parameter int WIDTH = 16,
  parameter int CH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    cycle,
  input  logic [CH*WIDTH-1:0] duty,
  input  logic                center,
  output logic [CH-1:0]       pwm_out,
  output logic                period_end,
  output logic                load_ack
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] act_cycle, pend_cycle;
  logic [WIDTH-1:0] act_duty  [CH];
  logic [WIDTH-1:0] pend_duty [CH];
  logic             act_center, pend_center, pend_vld;

  logic [WIDTH-1:0] cnt, cnt_nxt;
  dir_t             dir, dir_nxt;

  logic             idle, bnd_run, apply;
  logic [CH-1:0]    pwm_nxt;
  logic             pe_nxt;

  always_comb begin
    idle    = !en || (act_cycle == '0);
    bnd_run = 1'b0;
    cnt_nxt = cnt;
    dir_nxt = dir;
    pwm_nxt = '0;

    if (act_center) bnd_run = (cnt == ONE) && (dir == DIR_DOWN);
    else            bnd_run = (cnt == act_cycle);

    // Idle clocks count as boundaries so a pending set is never stranded.
    apply  = (idle || bnd_run) && pend_vld;
    pe_nxt = !idle && bnd_run;

    if (apply || idle) begin
      cnt_nxt = ONE;
      dir_nxt = DIR_UP;
    end else if (!act_center) begin
      cnt_nxt = (cnt == act_cycle) ? ONE : cnt + ONE;
    end else if (dir == DIR_UP) begin
      // Endpoints are held one extra clock to get a 2C period without 2C math.
      if (cnt == act_cycle) dir_nxt = DIR_DOWN;
      else                  cnt_nxt = cnt + ONE;
    end else begin
      if (cnt == ONE) dir_nxt = DIR_UP;
      else            cnt_nxt = cnt - ONE;
    end

    for (int i = 0; i < CH; i++) begin
      pwm_nxt[i] = !idle && (cnt <= act_duty[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cycle   <= '0;
      act_center  <= 1'b0;
      pend_cycle  <= '0;
      pend_center <= 1'b0;
      pend_vld    <= 1'b0;
      cnt         <= ONE;
      dir         <= DIR_UP;
      pwm_out     <= '0;
      period_end  <= 1'b0;
      load_ack    <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        act_duty[i]  <= '0;
        pend_duty[i] <= '0;
      end
    end else begin
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      pwm_out    <= pwm_nxt;
      period_end <= pe_nxt;
      load_ack   <= apply;

      // Apply uses the set pending before this clock; a same-clock load
      // becomes the next pending set.
      if (apply) begin
        act_cycle  <= pend_cycle;
        act_center <= pend_center;
        for (int i = 0; i < CH; i++) act_duty[i] <= pend_duty[i];
      end

      if (load) begin
        pend_cycle  <= cycle;
        pend_center <= center;
        pend_vld    <= 1'b1;
        for (int i = 0; i < CH; i++) pend_duty[i] <= duty[i*WIDTH +: WIDTH];
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
module tb_pwm_multi_ch;
  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, load, center;
  logic [W-1:0] cycle;
  logic [N*W-1:0] duty;
  logic [N-1:0] pwm_out;
  logic         period_end, load_ack;

  pwm_multi_ch #(.WIDTH(W), .CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .cycle(cycle),
    .duty(duty), .center(center), .pwm_out(pwm_out),
    .period_end(period_end), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: position within the current period (0..P-1).
  int m_c, m_ctr, m_pend, p_c, p_ctr, m_pos;
  int md[N];
  int pd[N];
  logic [N-1:0] e_pwm;
  logic e_pe, e_ack;

  int hi_cnt[N];
  int pe_cnt, ack_cnt;
  int n;
  logic found;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_ctr = 0; m_pend = 0; p_c = 0; p_ctr = 0; m_pos = 0;
    for (int i = 0; i < N; i++) begin md[i] = 0; pd[i] = 0; end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    pe_cnt = 0; ack_cnt = 0;
  endtask

  task automatic tick();
    int per, cntv;
    logic idle, bnd;
    if (!load) begin
      // Input changes without a load strobe must be ignored.
      cycle  = W'($urandom);
      duty   = {$urandom, $urandom};
      center = 1'($urandom);
    end
    idle = !en || (m_c == 0);
    per  = m_ctr ? 2 * m_c : m_c;
    bnd  = idle || (m_pos == per - 1);
    if (m_ctr) cntv = (m_pos < m_c) ? m_pos + 1 : 2 * m_c - m_pos;
    else       cntv = m_pos + 1;
    for (int i = 0; i < N; i++) e_pwm[i] = !idle && (cntv <= md[i]);
    e_pe  = !idle && (m_pos == per - 1);
    e_ack = bnd && (m_pend != 0);

    @(posedge clk); #1;
    chk("pwm_out", int'(pwm_out), int'(e_pwm));
    chk("period_end", int'(period_end), int'(e_pe));
    chk("load_ack", int'(load_ack), int'(e_ack));
    for (int i = 0; i < N; i++) hi_cnt[i] += int'(pwm_out[i]);
    pe_cnt  += int'(period_end);
    ack_cnt += int'(load_ack);

    if (e_ack) begin
      m_c = p_c; m_ctr = p_ctr;
      for (int i = 0; i < N; i++) md[i] = pd[i];
      m_pos = 0;
    end else if (idle) m_pos = 0;
    else m_pos = (m_pos + 1) % per;
    if (load) begin
      p_c = int'(cycle); p_ctr = int'(center); m_pend = 1;
      for (int i = 0; i < N; i++) pd[i] = int'(duty[i*W +: W]);
    end else if (e_ack) m_pend = 0;
  endtask

  task automatic do_load(input int c, input int d0, input int d1,
                         input int d2, input int d3, input logic ctr);
    cycle  = W'(c);
    duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    center = ctr;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // Ticks until load_ack (sel=0) or period_end (sel=1), bounded.
  task automatic wait_for(input int sel, input int limit, output int cnt_o, output logic hit);
    hit = 1'b0; cnt_o = 0;
    while (!hit && cnt_o < limit) begin
      tick();
      cnt_o++;
      hit = (sel == 0) ? load_ack : period_end;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; center = 1'b0;
    cycle = '0; duty = '0;
    model_reset();
    clr_counts();
    #12;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_pe", int'(period_end), 0);
    chk("rst_ack", int'(load_ack), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: edge mode, mixed duties
    en = 1'b1;
    do_load(10, 3, 0, 10, 15, 1'b0);
    wait_for(0, 5, n, found);
    chk("t1_ack_latency", n, 1);
    clr_counts();
    repeat (20) tick();
    chk("t1_hi0", hi_cnt[0], 6);
    chk("t1_hi1", hi_cnt[1], 0);
    chk("t1_hi2", hi_cnt[2], 20);
    chk("t1_hi3", hi_cnt[3], 20);
    chk("t1_pe", pe_cnt, 2);

    // 2: center mode
    do_load(8, 3, 8, 0, 1, 1'b1);
    wait_for(0, 30, n, found);
    chk("t2_ack_seen", int'(found), 1);
    clr_counts();
    repeat (16) tick();
    chk("t2_hi0", hi_cnt[0], 6);
    chk("t2_hi1", hi_cnt[1], 16);
    chk("t2_hi3", hi_cnt[3], 2);
    chk("t2_pe", pe_cnt, 1);

    // 3: reload mid-period completes the old period first
    do_load(10, 5, 2, 7, 9, 1'b0);
    wait_for(0, 30, n, found);
    chk("t3_ack_seen", int'(found), 1);
    tick();
    do_load(4, 1, 2, 3, 4, 1'b0);
    wait_for(0, 30, n, found);
    chk("t3_wait", n, 8);
    clr_counts();
    repeat (8) tick();
    chk("t3_pe", pe_cnt, 2);
    chk("t3_hi2", hi_cnt[2], 6);

    // 4: two loads in one period, last wins
    wait_for(1, 10, n, found);
    chk("t4_pe_seen", int'(found), 1);
    do_load(6, 1, 1, 1, 1, 1'b0);
    do_load(12, 4, 0, 12, 2, 1'b0);
    clr_counts();
    wait_for(0, 10, n, found);
    chk("t4_ack_seen", int'(found), 1);
    repeat (24) tick();
    chk("t4_acks", ack_cnt, 1);
    chk("t4_hi0", hi_cnt[0], 8);

    // 5: load while disabled
    en = 1'b0;
    repeat (2) tick();
    clr_counts();
    do_load(5, 2, 5, 0, 3, 1'b0);
    repeat (3) tick();
    chk("t5_acks", ack_cnt, 1);
    chk("t5_hi1", hi_cnt[1], 0);
    en = 1'b1;
    wait_for(1, 20, n, found);
    chk("t5_first_pe", n, 5);

    // 6: async reset mid-period
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pwm", int'(pwm_out), 0);
    chk("t6_pe", int'(period_end), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    clr_counts();
    repeat (10) tick();
    chk("t6_idle_pe", pe_cnt, 0);
    chk("t6_idle_ack", ack_cnt, 0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 14) == 0) begin
        int c;
        c = $urandom_range(1, 20);
        do_load(c, $urandom_range(0, c + 3), $urandom_range(0, c + 3),
                $urandom_range(0, c + 3), $urandom_range(0, c + 3), 1'($urandom));
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
